psum_axis_out_buffer: RTL and testbench

- Downstream neighbour of the 1-bit psum packer.
- Accepts its 32-bit packed words (valid/last, no backpressure) and buffers them in a synchronous FIFO.
- Drives an AXI4-Stream master toward the DMA with full TVALID/TREADY handshaking.
- Reports fill level, almost-full for upstream throttling, a sticky overflow flag, and a per-layer beat count plus done pulse.

---
 rtl/psum_axis_out_buffer_pkg.sv | 21 ++
 rtl/psum_sync_fifo.sv | 48 ++++
 rtl/psum_axis_out_buffer.sv | 126 ++++++++++++
 tb/tb_psum_axis_out_buffer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_axis_out_buffer_pkg.sv
// Shared constants and helpers for the psum output stages.
// Sizing function, default FIFO sizing and the AXIS strobe constant.
package psum_axis_out_buffer_pkg;

    localparam int DEF_FIFO_DEPTH     = 64;
    localparam int DEF_ALMOST_FULL_TH = 56;

    // Wide enough for any stream width up to 1024 bits; sliced by users.
    localparam logic [127:0] AXIS_STRB_ALL = '1;

    // Ceiling of log2(n); clogb2(1) = 0.
    function automatic int clogb2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/psum_sync_fifo.sv
// Synchronous show-ahead FIFO with wrap-bit pointers and an entry count.
// The head entry is visible on rd_data whenever empty is low.
module psum_sync_fifo
    import psum_axis_out_buffer_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH,
    parameter int WIDTH = 33
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [clogb2(DEPTH):0]   count
);

    localparam int AW = clogb2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Storage array; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    // Pointer advance; caller guarantees no write-when-full without a read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/psum_axis_out_buffer.sv
// Buffers packed psum words and streams them out over AXI4-Stream.
// Adds the output register, overflow flag, beat counter and layer_done.
module psum_axis_out_buffer
    import psum_axis_out_buffer_pkg::*;
#(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int FIFO_DEPTH           = DEF_FIFO_DEPTH,
    parameter int ALMOST_FULL_TH       = DEF_ALMOST_FULL_TH,
    parameter int BEAT_CNT_WIDTH       = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    input  logic                                in_last,
    input  logic [C_M_AXIS_TDATA_WIDTH-1:0]     in_data,
    input  logic                                layer_start,
    output logic                                M_AXIS_TVALID,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
    output logic                                M_AXIS_TLAST,
    input  logic                                M_AXIS_TREADY,
    output logic [clogb2(FIFO_DEPTH+1)-1:0]     level,
    output logic                                almost_full,
    output logic                                overflow,
    output logic [BEAT_CNT_WIDTH-1:0]           beat_cnt,
    output logic                                layer_done
);

    localparam int DW     = C_M_AXIS_TDATA_WIDTH;
    localparam int STRB_W = DW / 8;
    localparam int LVL_W  = clogb2(FIFO_DEPTH + 1);
    localparam int CNT_W  = clogb2(FIFO_DEPTH) + 1;

    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [DW:0]      fifo_rdata;
    logic             push;
    logic             pop;
    logic             hs;
    logic             drop;
    logic             out_valid;
    logic             out_last;
    logic [DW-1:0]    out_data;
    logic [LVL_W-1:0] level_nxt;

    // Handshake, FIFO read/write and drop qualification.
    always_comb begin
        hs   = out_valid && M_AXIS_TREADY;
        pop  = !fifo_empty && (!out_valid || hs);
        push = in_valid && (!fifo_full || pop);
        drop = in_valid && fifo_full && !pop;
    end

    psum_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DW + 1)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data ({in_last, in_data}),
        .rd_en   (pop),
        .rd_data (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // AXIS output register: refill on empty or on a completed beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (pop) begin
            out_valid <= 1'b1;
            out_last  <= fifo_rdata[DW];
            out_data  <= fifo_rdata[DW-1:0];
        end else if (hs) begin
            out_valid <= 1'b0;
        end
    end

    assign M_AXIS_TVALID = out_valid;
    assign M_AXIS_TDATA  = out_data;
    assign M_AXIS_TLAST  = out_last;
    assign M_AXIS_TSTRB  = out_valid ? AXIS_STRB_ALL[STRB_W-1:0] : '0;

    // Occupancy seen by upstream: FIFO entries plus the output register.
    always_comb begin
        level     = LVL_W'(fifo_count) + LVL_W'(out_valid);
        level_nxt = level + LVL_W'(push) - LVL_W'(hs);
    end

    // Throttle hint registered from next-state occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) almost_full <= 1'b0;
        else        almost_full <= (level_nxt >= LVL_W'(ALMOST_FULL_TH));
    end

    // Sticky drop flag; a drop in the clearing cycle still sets it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           overflow <= 1'b0;
        else if (drop)        overflow <= 1'b1;
        else if (layer_start) overflow <= 1'b0;
    end

    // Saturating per-layer beat counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (layer_start) begin
            beat_cnt <= hs ? BEAT_CNT_WIDTH'(1) : '0;
        end else if (hs && (beat_cnt != '1)) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

    // One-cycle pulse after the final beat of a layer is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) layer_done <= 1'b0;
        else        layer_done <= hs && out_last;
    end

endmodule

// File: tb/tb_psum_axis_out_buffer.sv
// Self-checking bench: directed vector table, directed corner sequences
// and randomized traffic against a queue-based reference model.
module tb_psum_axis_out_buffer;

    localparam int DEPTH = 64;
    localparam int TH    = 56;
    localparam int CAP   = DEPTH + 1;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_last;
    logic [31:0] in_data;
    logic        layer_start;
    logic        tvalid;
    logic [31:0] tdata;
    logic [3:0]  tstrb;
    logic        tlast;
    logic        tready;
    logic [6:0]  level;
    logic        almost_full;
    logic        overflow;
    logic [15:0] beat_cnt;
    logic        layer_done;

    psum_axis_out_buffer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_last       (in_last),
        .in_data       (in_data),
        .layer_start   (layer_start),
        .M_AXIS_TVALID (tvalid),
        .M_AXIS_TDATA  (tdata),
        .M_AXIS_TSTRB  (tstrb),
        .M_AXIS_TLAST  (tlast),
        .M_AXIS_TREADY (tready),
        .level         (level),
        .almost_full   (almost_full),
        .overflow      (overflow),
        .beat_cnt      (beat_cnt),
        .layer_done    (layer_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nchk;
    int nerr;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: every word held by the block, oldest first.
    typedef struct {
        logic [31:0] d;
        logic        l;
        int          stamp;
    } ent_t;

    ent_t q[$];
    int   edge_cnt;
    bit   m_ovf;
    int   m_beat;
    bit   m_done;

    task automatic model_clear();
        q.delete();
        m_ovf  = 1'b0;
        m_beat = 0;
        m_done = 1'b0;
    endtask

    // Compare all outputs with the model, then apply one clock of stimulus.
    task automatic cycle(input bit iv, input bit il, input logic [31:0] id,
                         input bit rdy, input bit ls);
        bit   ev;
        bit   hs;
        bit   acc;
        ent_t e;
        ev = (q.size() > 0) && (q[0].stamp <= edge_cnt - 1);
        chk("tvalid", 32'(tvalid), 32'(ev));
        if (ev) begin
            chk("tdata", tdata, q[0].d);
            chk("tlast", 32'(tlast), 32'(q[0].l));
        end
        chk("tstrb", 32'(tstrb), ev ? 32'hF : 32'h0);
        chk("level", 32'(level), q.size());
        chk("almost_full", 32'(almost_full), 32'(q.size() >= TH));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("beat_cnt", 32'(beat_cnt), m_beat);
        chk("layer_done", 32'(layer_done), 32'(m_done));

        in_valid    = iv;
        in_last     = il;
        in_data     = id;
        tready      = rdy;
        layer_start = ls;

        hs     = ev && rdy;
        m_done = hs && q[0].l;
        acc    = iv && ((q.size() < CAP) || hs);
        if (hs) void'(q.pop_front());
        if (acc) begin
            e.d = id;
            e.l = il;
            e.stamp = edge_cnt + 1;
            q.push_back(e);
        end
        if (iv && !acc) m_ovf = 1'b1;
        else if (ls)    m_ovf = 1'b0;
        if (ls)                   m_beat = hs ? 1 : 0;
        else if (hs && m_beat < 65535) m_beat = m_beat + 1;

        @(posedge clk);
        edge_cnt++;
        @(negedge clk);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_tvalid"}, 32'(tvalid), 0);
        chk({nm, "_tdata"}, tdata, 0);
        chk({nm, "_tlast"}, 32'(tlast), 0);
        chk({nm, "_tstrb"}, 32'(tstrb), 0);
        chk({nm, "_level"}, 32'(level), 0);
        chk({nm, "_af"}, 32'(almost_full), 0);
        chk({nm, "_ovf"}, 32'(overflow), 0);
        chk({nm, "_beat"}, 32'(beat_cnt), 0);
        chk({nm, "_done"}, 32'(layer_done), 0);
    endtask

    typedef struct {
        logic        iv;
        logic        il;
        logic [31:0] id;
        logic        rdy;
        logic        e_valid;
        logic [31:0] e_data;
        logic        e_last;
        logic [3:0]  e_strb;
        int          e_level;
        int          e_beat;
        logic        e_done;
    } vec_t;

    vec_t tbl[8];

    initial begin
        nchk = 0;
        nerr = 0;
        edge_cnt = 0;
        model_clear();

        // Inputs applied before the edge, outputs expected after it.
        tbl[0] = '{1, 1, 32'h0000_00A5, 1, 0, 32'h0, 0, 4'h0, 1, 0, 0};
        tbl[1] = '{0, 0, 32'h0,         1, 1, 32'h0000_00A5, 1, 4'hF, 1, 0, 0};
        tbl[2] = '{0, 0, 32'h0,         1, 0, 32'h0, 0, 4'h0, 0, 1, 1};
        tbl[3] = '{0, 0, 32'h0,         1, 0, 32'h0, 0, 4'h0, 0, 1, 0};
        tbl[4] = '{1, 0, 32'h1234_5678, 0, 0, 32'h0, 0, 4'h0, 1, 1, 0};
        tbl[5] = '{0, 0, 32'h0,         0, 1, 32'h1234_5678, 0, 4'hF, 1, 1, 0};
        tbl[6] = '{0, 0, 32'h0,         0, 1, 32'h1234_5678, 0, 4'hF, 1, 1, 0};
        tbl[7] = '{0, 0, 32'h0,         1, 0, 32'h0, 0, 4'h0, 0, 2, 0};

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_data = '0;
        layer_start = 1'b0;
        tready = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 8; k++) begin
            in_valid = tbl[k].iv;
            in_last  = tbl[k].il;
            in_data  = tbl[k].id;
            tready   = tbl[k].rdy;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d_tvalid", k), 32'(tvalid), 32'(tbl[k].e_valid));
            if (tbl[k].e_valid) begin
                chk($sformatf("vec%0d_tdata", k), tdata, tbl[k].e_data);
                chk($sformatf("vec%0d_tlast", k), 32'(tlast), 32'(tbl[k].e_last));
            end
            chk($sformatf("vec%0d_tstrb", k), 32'(tstrb), 32'(tbl[k].e_strb));
            chk($sformatf("vec%0d_level", k), 32'(level), tbl[k].e_level);
            chk($sformatf("vec%0d_beat", k), 32'(beat_cnt), tbl[k].e_beat);
            chk($sformatf("vec%0d_done", k), 32'(layer_done), 32'(tbl[k].e_done));
        end

        // Model picks up from the table's end state: empty, two beats.
        model_clear();
        m_beat = 2;

        // Burst of 40 with sink always ready.
        cycle(0, 0, 0, 1, 1);
        for (int i = 0; i < 40; i++) begin
            cycle(1, i == 39, 32'(i), 1, 0);
            chk("burst_level_le2", 32'(level <= 2), 1);
        end
        repeat (4) cycle(0, 0, 0, 1, 0);
        chk("burst_beats", 32'(beat_cnt), 40);

        // Fill to capacity with the sink stalled.
        cycle(0, 0, 0, 0, 1);
        for (int i = 0; i < CAP; i++) cycle(1, 0, 32'h1000 + 32'(i), 0, 0);
        chk("fill_level", 32'(level), 65);
        chk("fill_af", 32'(almost_full), 1);
        chk("fill_ovf", 32'(overflow), 0);
        chk("fill_head", tdata, 32'h1000);
        cycle(1, 1, 32'h2000, 0, 0);
        chk("drop_ovf", 32'(overflow), 1);
        chk("drop_level", 32'(level), 65);
        cycle(0, 0, 0, 0, 1);
        chk("ls_ovf_clr", 32'(overflow), 0);
        chk("ls_beat_clr", 32'(beat_cnt), 0);
        cycle(1, 1, 32'h3000, 1, 0);
        chk("full_pop_level", 32'(level), 65);
        chk("full_pop_ovf", 32'(overflow), 0);
        repeat (70) cycle(0, 0, 0, 1, 0);
        chk("drain_empty", 32'(level), 0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 9) < 6, $urandom_range(0, 7) == 0,
                  $urandom, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 31) == 0);
        end
        repeat (80) cycle(0, 0, 0, 1, 0);

        // Mid-stream reset with words buffered and TVALID high.
        for (int i = 0; i < 10; i++) cycle(1, 0, 32'hB000 + 32'(i), 0, 0);
        cycle(0, 0, 0, 0, 0);
        chk("pre_rst_tvalid", 32'(tvalid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
        cycle(1, 1, 32'hCAFE_0001, 1, 0);
        repeat (4) cycle(0, 0, 0, 1, 0);
        chk("post_rst_beats", 32'(beat_cnt), 1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
